// File: rtl/obstacle_spawner_pkg.sv
// Shared game constants, state codes and LFSR helpers for the obstacle spawner.
package obstacle_spawner_pkg;

    // Common game constants
    localparam int UBYTE_W    = 8;
    localparam int X_MAX      = 159;   // last visible screen column
    localparam int OBS_W_PX   = 8;     // obstacle width in pixels
    localparam int MIN_OBS_H  = 8;     // smallest obstacle height
    localparam int GROUND_TOP = 100;   // first row of the ground strip

    // Controller game-state codes
    localparam logic [3:0] GAME_MENU    = 4'd0;
    localparam logic [3:0] GAME_RUNNING = 4'd1;
    localparam logic [3:0] GAME_PAUSE   = 4'd2;
    localparam logic [3:0] GAME_OVER    = 4'd3;

    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_SPAWN = 1'b1
    } spawn_state_t;

    // One Galois step; a nonzero state never maps to zero.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic [15:0] shifted;
        shifted = {1'b0, v[15:1]};
        return v[0] ? (shifted ^ LFSR_TAPS) : shifted;
    endfunction

endpackage

// File: rtl/obstacle_spawner_lfsr16.sv
// 16-bit Galois LFSR used as the randomness source for obstacle respawns.
module lfsr16
    import obstacle_spawner_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    // Load the seed in reset, otherwise advance one Galois step per enabled cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            q <= seed;
        end else if (enable) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/obstacle_spawner.sv
// Owns the two obstacle slots: scrolls them left on each step tick and, when a
// slot reaches column 0, respawns it off-screen right with a random gap and height.
module obstacle_spawner
    import obstacle_spawner_pkg::*;
#(
    parameter int          OBS_W     = OBS_W_PX,
    parameter int          MIN_GAP   = 40,
    parameter int          GAP_BITS  = 6,
    parameter int          SPAWN_X   = X_MAX + 1,
    parameter int          MIN_H     = MIN_OBS_H,
    parameter int          H_BITS    = 4,
    parameter int          INIT_X1   = 120,
    parameter int          INIT_X2   = 254,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [3:0]   gameState,
    input  logic         step,
    output logic [7:0]   obs1X,
    output logic [7:0]   obs1H,
    output logic [7:0]   obs2X,
    output logic [7:0]   obs2H,
    output logic         spawnPulse,
    output logic         busy
);

    localparam logic [7:0] INIT_X1_B = 8'(INIT_X1);
    localparam logic [7:0] INIT_X2_B = 8'(INIT_X2);
    localparam logic [7:0] INIT_H1   = 8'(MIN_H);
    localparam logic [7:0] INIT_H2   = 8'(MIN_H + (1 << H_BITS) - 1);
    localparam logic [8:0] SPACING   = 9'(OBS_W + MIN_GAP);
    localparam logic [8:0] SPAWN_X_9 = 9'(SPAWN_X);

    spawn_state_t          state;
    logic [1:0]            pending;
    logic [15:0]           lfsr_q;
    logic [GAP_BITS-1:0]   gap_rand;
    logic [H_BITS-1:0]     h_rand;
    logic                  lfsr_unused;
    logic                  run_step;

    // Free-running randomness: it advances in every state, so player timing
    // (when MENU is left, when PAUSE is pressed) perturbs the spawn sequence.
    lfsr16 u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .enable (1'b1),
        .seed   (LFSR_SEED),
        .q      (lfsr_q)
    );

    assign gap_rand = lfsr_q[GAP_BITS-1:0];
    assign h_rand   = lfsr_q[H_BITS+7:8];
    // Bits outside the gap and height fields are deliberately left unused.
    assign lfsr_unused = ^lfsr_q;

    assign run_step = step && (gameState == GAME_RUNNING);

    // Clamp a 9-bit sum into the 8-bit X range.
    function automatic logic [7:0] sat_u8(input logic [8:0] sum);
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // New left X for a respawned slot: behind the other slot by the minimum
    // spacing plus a random gap, never on-screen, saturated at 255.
    function automatic logic [7:0] place_x(input logic [7:0]          other,
                                           input logic [GAP_BITS-1:0] gap);
        logic [8:0] sum;
        sum = {1'b0, other} + SPACING + 9'(gap);
        if (sum < SPAWN_X_9) begin
            return SPAWN_X_9[7:0];
        end
        return sat_u8(sum);
    endfunction

    function automatic logic [7:0] spawn_h(input logic [H_BITS-1:0] r);
        return 8'(MIN_H) + 8'(r);
    endfunction

    // Scroll / respawn state machine; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (!resetn || gameState == GAME_MENU) begin
            // MENU reloads the same layout as reset and aborts any pending respawn.
            obs1X      <= INIT_X1_B;
            obs1H      <= INIT_H1;
            obs2X      <= INIT_X2_B;
            obs2H      <= INIT_H2;
            spawnPulse <= 1'b0;
            busy       <= 1'b0;
            pending    <= 2'b00;
            state      <= S_RUN;
        end else begin
            spawnPulse <= 1'b0;
            case (state)
                S_RUN: begin
                    if (run_step) begin
                        // A slot already at column 0 parks there and is queued for respawn.
                        if (obs1X == 8'd0) begin
                            pending[0] <= 1'b1;
                        end else begin
                            obs1X <= obs1X - 8'd1;
                        end
                        if (obs2X == 8'd0) begin
                            pending[1] <= 1'b1;
                        end else begin
                            obs2X <= obs2X - 8'd1;
                        end
                        if (obs1X == 8'd0 || obs2X == 8'd0) begin
                            state <= S_SPAWN;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_SPAWN: begin
                    // Respawns are serialised, slot 1 first, so a second respawn
                    // is spaced against the freshly placed first one.
                    spawnPulse <= 1'b1;
                    if (pending[0]) begin
                        obs1X      <= place_x(obs2X, gap_rand);
                        obs1H      <= spawn_h(h_rand);
                        pending[0] <= 1'b0;
                        if (!pending[1]) begin
                            state <= S_RUN;
                            busy  <= 1'b0;
                        end
                    end else begin
                        obs2X      <= place_x(obs1X, gap_rand);
                        obs2H      <= spawn_h(h_rand);
                        pending[1] <= 1'b0;
                        state      <= S_RUN;
                        busy       <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Bench for obstacle_spawner: directed vector table, hand sequences for the
// respawn corner cases, and a cycle scoreboard over three parameterisations.
module tb_obstacle_spawner;
    import obstacle_spawner_pkg::*;

    typedef struct packed {
        logic [7:0] x1;
        logic [7:0] h1;
        logic [7:0] x2;
        logic [7:0] h2;
        logic       pulse;
        logic       busy;
    } out_t;

    typedef out_t [2:0] trio_t;

    typedef struct packed {
        out_t       o;
        logic [1:0] pend;
        logic       sp;
    } mstate_t;

    typedef struct {
        logic       r;
        logic [3:0] g;
        logic       s;
        out_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] gameState;
    logic       step;

    logic [7:0] a_x1, a_h1, a_x2, a_h2, b_x1, b_h1, b_x2, b_h2;
    logic [7:0] c_x1, c_h1, c_x2, c_h2, d_x1, d_h1, d_x2, d_h2;
    logic       a_sp, a_bz, b_sp, b_bz, c_sp, c_bz, d_sp, d_bz;

    trio_t act;
    out_t  twin;

    int errors = 0;
    int checks = 0;
    int lfsr_bad = 0;
    int lfsr_zero = 0;
    int twin_bad = 0;
    bit sb_on = 1'b1;

    mstate_t     ms [3];
    int          ix1 [3] = '{120, 5, 0};
    int          ix2 [3] = '{254, 5, 250};
    logic [15:0] mlfsr = 16'hACE1;
    trio_t       exp_q [$];
    vec_t        tbl [9];

    always #5 clk = ~clk;

    obstacle_spawner dut_a (
        .clk(clk), .resetn(resetn), .gameState(gameState), .step(step),
        .obs1X(a_x1), .obs1H(a_h1), .obs2X(a_x2), .obs2H(a_h2),
        .spawnPulse(a_sp), .busy(a_bz)
    );
    obstacle_spawner #(.INIT_X1(5), .INIT_X2(5)) dut_b (
        .clk(clk), .resetn(resetn), .gameState(gameState), .step(step),
        .obs1X(b_x1), .obs1H(b_h1), .obs2X(b_x2), .obs2H(b_h2),
        .spawnPulse(b_sp), .busy(b_bz)
    );
    obstacle_spawner #(.INIT_X1(0), .INIT_X2(250)) dut_c (
        .clk(clk), .resetn(resetn), .gameState(gameState), .step(step),
        .obs1X(c_x1), .obs1H(c_h1), .obs2X(c_x2), .obs2H(c_h2),
        .spawnPulse(c_sp), .busy(c_bz)
    );
    obstacle_spawner dut_d (
        .clk(clk), .resetn(resetn), .gameState(gameState), .step(step),
        .obs1X(d_x1), .obs1H(d_h1), .obs2X(d_x2), .obs2H(d_h2),
        .spawnPulse(d_sp), .busy(d_bz)
    );

    assign act  = {{c_x1, c_h1, c_x2, c_h2, c_sp, c_bz},
                   {b_x1, b_h1, b_x2, b_h2, b_sp, b_bz},
                   {a_x1, a_h1, a_x2, a_h2, a_sp, a_bz}};
    assign twin = {d_x1, d_h1, d_x2, d_h2, d_sp, d_bz};

    function automatic out_t mk_out(input int x1, input int h1, input int x2,
                                    input int h2, input logic p, input logic b);
        out_t o;
        o.x1 = 8'(x1); o.h1 = 8'(h1); o.x2 = 8'(x2); o.h2 = 8'(h2);
        o.pulse = p; o.busy = b;
        return o;
    endfunction

    function automatic logic [15:0] ref_lfsr(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [7:0] exp_place(input logic [7:0] other, input logic [15:0] l);
        int sum;
        sum = int'(other) + 8 + 40 + int'(l[5:0]);
        if (sum > 255) sum = 255;
        if (sum < 160) sum = 160;
        return 8'(sum);
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input logic r, input logic [3:0] g,
                                           input logic st, input logic [15:0] l,
                                           input int x1i, input int x2i);
        mstate_t n;
        n = s;
        n.o.pulse = 1'b0;
        if (!r || g == GAME_MENU) begin
            n.o = mk_out(x1i, 8, x2i, 23, 1'b0, 1'b0);
            n.pend = 2'b00;
            n.sp = 1'b0;
        end else if (!s.sp) begin
            if (st && g == GAME_RUNNING) begin
                if (s.o.x1 == 8'd0) n.pend[0] = 1'b1; else n.o.x1 = s.o.x1 - 8'd1;
                if (s.o.x2 == 8'd0) n.pend[1] = 1'b1; else n.o.x2 = s.o.x2 - 8'd1;
                if (n.pend != 2'b00) begin
                    n.sp = 1'b1;
                    n.o.busy = 1'b1;
                end
            end
        end else if (s.pend[0]) begin
            n.o.x1 = exp_place(s.o.x2, l);
            n.o.h1 = 8'(8 + int'(l[11:8]));
            n.pend[0] = 1'b0;
            n.o.pulse = 1'b1;
            if (!s.pend[1]) begin
                n.sp = 1'b0;
                n.o.busy = 1'b0;
            end
        end else begin
            n.o.x2 = exp_place(s.o.x1, l);
            n.o.h2 = 8'(8 + int'(l[11:8]));
            n.pend[1] = 1'b0;
            n.o.pulse = 1'b1;
            n.sp = 1'b0;
            n.o.busy = 1'b0;
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, a, e);
        end
    endtask

    task automatic chk_rng(input string nm, input int a, input int lo, input int hi);
        checks++;
        if (a < lo || a > hi) begin
            errors++;
            $display("FAIL %s: actual=%0d required=[%0d,%0d]", nm, a, lo, hi);
        end
    endtask

    // One clock: drive inputs, queue the predicted outputs, compare after the edge.
    task automatic cyc(input logic r, input logic [3:0] g, input logic s);
        trio_t e;
        resetn = r; gameState = g; step = s;
        for (int k = 0; k < 3; k++) begin
            ms[k] = model_next(ms[k], r, g, s, mlfsr, ix1[k], ix2[k]);
            e[k] = ms[k].o;
        end
        exp_q.push_back(e);
        mlfsr = r ? ref_lfsr(mlfsr) : 16'hACE1;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (sb_on) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("scoreboard_dut%0d", k), 64'(act[k]), 64'(e[k]));
            end
        end
        if (dut_a.u_lfsr.q !== mlfsr) lfsr_bad++;
        if (dut_a.u_lfsr.q == 16'd0) lfsr_zero++;
        if (act[0] !== twin) twin_bad++;
        @(negedge clk);
    endtask

    initial begin
        out_t save;
        int   cnt;

        resetn = 1'b0; gameState = GAME_RUNNING; step = 1'b0;
        @(negedge clk);

        // Directed vectors for dut_a: reset, step, hold states, MENU, reset priority
        tbl[0] = '{1'b0, GAME_RUNNING, 1'b0, mk_out(120, 8, 254, 23, 1'b0, 1'b0)};
        tbl[1] = '{1'b1, GAME_RUNNING, 1'b1, mk_out(119, 8, 253, 23, 1'b0, 1'b0)};
        tbl[2] = '{1'b1, GAME_RUNNING, 1'b0, mk_out(119, 8, 253, 23, 1'b0, 1'b0)};
        tbl[3] = '{1'b1, GAME_PAUSE,   1'b1, mk_out(119, 8, 253, 23, 1'b0, 1'b0)};
        tbl[4] = '{1'b1, GAME_OVER,    1'b1, mk_out(119, 8, 253, 23, 1'b0, 1'b0)};
        tbl[5] = '{1'b1, GAME_RUNNING, 1'b1, mk_out(118, 8, 252, 23, 1'b0, 1'b0)};
        tbl[6] = '{1'b1, GAME_MENU,    1'b1, mk_out(120, 8, 254, 23, 1'b0, 1'b0)};
        tbl[7] = '{1'b1, GAME_RUNNING, 1'b1, mk_out(119, 8, 253, 23, 1'b0, 1'b0)};
        tbl[8] = '{1'b0, GAME_RUNNING, 1'b1, mk_out(120, 8, 254, 23, 1'b0, 1'b0)};
        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].r, tbl[i].g, tbl[i].s);
            chk($sformatf("vector%0d", i), 64'(act[0]), 64'(tbl[i].e));
        end

        // Steady run to the first slot-1 respawn; a step while busy is dropped
        cyc(1'b0, GAME_RUNNING, 1'b0);
        repeat (120) cyc(1'b1, GAME_RUNNING, 1'b1);
        chk("run120_x1", a_x1, 0);
        chk("run120_x2", a_x2, 134);
        cyc(1'b1, GAME_RUNNING, 1'b1);
        chk("step121_x1", a_x1, 0);
        chk("step121_x2", a_x2, 133);
        chk("step121_busy", a_bz, 1);
        chk("step121_pulse", a_sp, 0);
        cyc(1'b1, GAME_RUNNING, 1'b1);
        chk_rng("respawn_x1", a_x1, 181, 244);
        chk_rng("respawn_h1", a_h1, 8, 23);
        chk("respawn_pulse", a_sp, 1);
        chk("respawn_busy", a_bz, 0);
        chk("busy_step_dropped_x2", a_x2, 133);
        cyc(1'b1, GAME_RUNNING, 1'b0);
        chk("pulse_one_cycle", a_sp, 0);

        // Pause and game-over hold, then one step decrements by exactly one
        save = act[0];
        cnt = 0;
        repeat (10) begin
            cyc(1'b1, GAME_PAUSE, 1'b1);
            if (act[0] !== save) cnt++;
        end
        repeat (5) begin
            cyc(1'b1, GAME_OVER, 1'b1);
            if (act[0] !== save) cnt++;
        end
        chk("hold_changes", cnt, 0);
        cyc(1'b1, GAME_RUNNING, 1'b1);
        chk("resume_x1", a_x1, save.x1 - 8'd1);
        chk("resume_x2", a_x2, save.x2 - 8'd1);

        // Double respawn on dut_b (both slots start at 5)
        cyc(1'b0, GAME_RUNNING, 1'b0);
        repeat (6) cyc(1'b1, GAME_RUNNING, 1'b1);
        chk("dbl_busy_a", b_bz, 1);
        chk("dbl_pulse_a", b_sp, 0);
        chk("dbl_x_zero", {b_x1, b_x2}, 16'h0000);
        cyc(1'b1, GAME_RUNNING, 1'b0);
        chk("dbl_slot1_x", b_x1, 160);
        chk("dbl_pulse_b", b_sp, 1);
        chk("dbl_busy_b", b_bz, 1);
        cyc(1'b1, GAME_RUNNING, 1'b0);
        chk_rng("dbl_slot2_x", b_x2, 208, 255);
        chk("dbl_pulse_c", b_sp, 1);
        chk("dbl_busy_c", b_bz, 0);
        cyc(1'b1, GAME_RUNNING, 1'b0);
        chk("dbl_pulse_d", b_sp, 0);

        // X saturation on dut_c (slot 1 at 0, slot 2 at 250)
        cyc(1'b0, GAME_RUNNING, 1'b0);
        cyc(1'b1, GAME_RUNNING, 1'b1);
        chk("sat_x2", c_x2, 249);
        chk("sat_busy", c_bz, 1);
        cyc(1'b1, GAME_RUNNING, 1'b0);
        chk("sat_x1", c_x1, 255);
        chk("sat_pulse", c_sp, 1);

        // MENU while dut_b is mid-spawn aborts it
        cyc(1'b0, GAME_RUNNING, 1'b0);
        repeat (6) cyc(1'b1, GAME_RUNNING, 1'b1);
        chk("abort_pre_busy", b_bz, 1);
        cyc(1'b1, GAME_MENU, 1'b0);
        chk("abort_init", 64'(act[1]), 64'(mk_out(5, 8, 5, 23, 1'b0, 1'b0)));
        cnt = 0;
        repeat (4) begin
            cyc(1'b1, GAME_RUNNING, 1'b0);
            if (b_sp !== 1'b0) cnt++;
        end
        chk("abort_no_pulse", cnt, 0);

        // Long run: full LFSR period, twin determinism, never zero
        cyc(1'b0, GAME_RUNNING, 1'b0);
        sb_on = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            cyc(1'b1, ($urandom_range(0, 31) == 0) ? GAME_PAUSE : GAME_RUNNING,
                ($urandom_range(0, 40) == 0) ? 1'b1 : 1'b0);
        end
        chk("lfsr_period", dut_a.u_lfsr.q, 16'hACE1);
        sb_on = 1'b1;
        repeat (20) cyc(1'b1, GAME_RUNNING, 1'b1);
        chk("lfsr_zero_seen", lfsr_zero, 0);
        chk("lfsr_sequence", lfsr_bad, 0);
        chk("determinism_twin", twin_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
